data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Synchronous data-memory responder that serves load/store requests issued by the core's execute stage. It sits on the execute-to-memory interface and owns the data RAM array. Byte and half-word stores use a read-modify-write state machine. Loads return results already sign- or zero-extended according to func3. Misaligned and out-of-range accesses are rejected with an error response and no state change.

Parameters:
DATA_WIDTH, 32, word width in bits; only 32 is supported.
RAM_WIDTH, 31, width of the byte address from the requester.
DEPTH_WORDS, 256, number of 32-bit words in the array (power of two).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_func3  input  3  access size and signedness, RV32I encoding.
req_addr  input  RAM_WIDTH  byte address.
req_wdata  input  DATA_WIDTH  store data, right-aligned.
rsp_valid  output  1  response present.
rsp_ready  input  1  requester accepts the response.
rsp_rdata  output  DATA_WIDTH  load result, already extended; 0 for stores and errors.
rsp_err  output  1  misaligned access, out-of-range address, or illegal func3.

Behaviour:
- Reset: state IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Array contents are not reset.
- States: IDLE, RD, WR, RSP.
- Accept: a request is accepted on a rising edge with req_valid & req_ready. On accept, req_addr, req_func3, req_we and req_wdata are registered.
- req_ready is high only in IDLE. There is exactly one outstanding request at a time.
- Word index is req_addr[2+log2(DEPTH_WORDS)-1:2]. Byte offset is req_addr[1:0].
- Error check is evaluated at accept time. An error goes IDLE->RSP directly with rsp_err=1 and rsp_rdata=0, and the array is untouched. Error conditions:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - any address bit above the array range set;
  - illegal func3 (load 011/110/111; store other than 000/001/010).
- Load (LB=000, LH=001, LW=010, LBU=100, LHU=101): IDLE->RD (array read) ->RSP. rsp_valid rises 2 cycles after accept.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - The lane is selected by the byte offset: byte lanes 0..3, half lanes 0/2.
- Store word (SW=010): IDLE->WR (full write of req_wdata) ->RSP. rsp_valid rises 2 cycles after accept.
- Store sub-word (SB=000, SH=001): IDLE->RD (read old word) ->WR (merge the low byte/half of req_wdata into the selected lane, write back) ->RSP. rsp_valid rises 3 cycles after accept. Unselected lanes are preserved bit-exactly.
- RSP: rsp_valid and rsp_rdata/rsp_err are held stable until rsp_ready. RSP->IDLE on rsp_valid & rsp_ready. req_ready rises the cycle after the handshake, so there is no combinational ready path.
- A load issued after a store to the same word observes the new data; this holds automatically because the store has completed before IDLE is re-entered.
- Reset mid-operation: the FSM returns to IDLE immediately and any pending response is dropped. A WR not yet clocked does not occur; a WR already clocked stays in the array.
- Width rules: all merging and extension is done on 32-bit vectors. Address bits above the index range are compared against zero, not truncated.

Decomposition:
- Shared package mem_pkg holds:
  - func3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the state enum type mem_state_t (IDLE, RD, WR, RSP);
  - the access-size helper function size_of(func3).
  The ALU decode includes reuse the same func3 constants.
- One combinational sub-module, mem_lane_unit, provides:
  - the load lane extract + extend (inputs: word, offset, func3);
  - the store lane merge (inputs: old word, wdata, offset, func3).
  It is instantiated once and used in both RD and WR.

Test Plan:
- Reset: rst_n low mid-sequence -> req_ready=1, rsp_valid=0 within the same cycle; an SB in RD is dropped and the target word is unchanged.
- SW 0xDEADBEEF @0x10, then LW @0x10 -> store rsp_valid 2 cycles after accept, rsp_err=0; load returns 0xDEADBEEF 2 cycles after accept.
- SB 0x7F @0x11 over 0xDEADBEEF -> word = 0xDEAD7FEF; rsp_valid 3 cycles after accept.
  - LB @0x13 -> 0xFFFFFFDE.
  - LBU @0x13 -> 0x000000DE.
  - LH @0x12 -> 0xFFFFDEAD.
  - LHU @0x12 -> 0x0000DEAD.
- Misaligned: LW @0x12 and SH @0x11 -> rsp_err=1, rsp_rdata=0, 1 cycle after accept; array unchanged on readback.
- Out of range: LW @(DEPTH_WORDS*4)=0x400 -> rsp_err=1.
- Illegal func3: load with func3=011 -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles on a load -> rsp_rdata stable and req_ready=0 throughout; after the handshake, req_ready=1 on the next cycle; back-to-back requests are accepted without loss.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store func3 codes,
// FSM state type and access-size decode.
package mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} mem_state_t;

    typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_X = 2'd3} mem_size_t;

    function automatic mem_size_t size_of(input logic [2:0] func3);
        return mem_size_t'(func3[1:0]);
    endfunction

    function automatic logic func3_legal(input logic we, input logic [2:0] func3);
        if (we) return (func3 == SB) || (func3 == SH) || (func3 == SW);
        return (func3 == LB) || (func3 == LH) || (func3 == LW) ||
               (func3 == LBU) || (func3 == LHU);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Execute-to-memory request/response bus; the core is the master, the RAM owner the slave.
interface data_mem_responder_if #(
    parameter int RAM_WIDTH  = 31,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_func3;
    logic [RAM_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_lane_unit.sv
// Combinational byte/half lane logic: load extract with sign/zero extension,
// and store merge of the low byte/half of wdata into the selected lane.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);
    logic [4:0]  shamt;
    logic [15:0] lane;
    logic [31:0] mask;
    logic [31:0] ins;

    assign shamt = {offset, 3'b000};
    assign lane  = 16'(rd_word >> shamt);

    always_comb begin
        ld_data = '0;
        case (func3)
            LB:      ld_data = {{24{lane[7]}}, lane[7:0]};
            LH:      ld_data = {{16{lane[15]}}, lane[15:0]};
            LW:      ld_data = rd_word;
            LBU:     ld_data = {24'b0, lane[7:0]};
            LHU:     ld_data = {16'b0, lane[15:0]};
            default: ld_data = '0;
        endcase
    end

    // Unselected lanes pass through from the old word untouched.
    always_comb begin
        mask    = '0;
        ins     = '0;
        st_word = rd_word;
        case (size_of(func3))
            SZ_B: begin
                mask    = 32'h0000_00FF << shamt;
                ins     = {24'b0, wdata[7:0]} << shamt;
                st_word = (rd_word & ~mask) | ins;
            end
            SZ_H: begin
                mask    = 32'h0000_FFFF << shamt;
                ins     = {16'b0, wdata[15:0]} << shamt;
                st_word = (rd_word & ~mask) | ins;
            end
            SZ_W:    st_word = wdata;
            default: st_word = rd_word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder owning the data RAM; sub-word stores go through a
// read-modify-write pass (RD then WR), bad requests jump straight to RSP.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_WIDTH   = 31,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    mem_state_t            state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [1:0]            off_q, off_d;
    logic [2:0]            func3_q, func3_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  req_err;
    mem_size_t             req_size;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] st_word;

    assign accept   = bus.req_valid & bus.req_ready;
    assign req_size = size_of(bus.req_func3);

    // High address bits are compared against zero rather than dropped, so aliases error out.
    always_comb begin
        req_err = 1'b0;
        if (req_size == SZ_H && bus.req_addr[0])             req_err = 1'b1;
        if (req_size == SZ_W && bus.req_addr[1:0] != 2'b00)  req_err = 1'b1;
        if (|bus.req_addr[RAM_WIDTH-1:AW+2])                 req_err = 1'b1;
        if (!func3_legal(bus.req_we, bus.req_func3))         req_err = 1'b1;
    end

    assign rd_word = mem_q[idx_q];

    mem_lane_unit u_lane (
        .rd_word (rd_word),
        .offset  (off_q),
        .func3   (func3_q),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            off_q   <= '0;
            func3_q <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            func3_q <= func3_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; a WR state cut short by reset never reaches this edge.
    always_ff @(posedge clk) begin
        if (state_q == WR) mem_q[idx_q] <= st_word;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)                             state_d = RSP;
                    else if (bus.req_we && req_size == SZ_W) state_d = WR;
                    else                                     state_d = RD;
                end
            end
            RD:      state_d = we_q ? WR : RSP;
            WR:      state_d = RSP;
            RSP:     if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        off_d   = off_q;
        func3_d = func3_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = bus.req_addr[AW+1:2];
                    off_d   = bus.req_addr[1:0];
                    func3_d = bus.req_func3;
                    we_d    = bus.req_we;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = req_err;
                end
            end
            RD:      if (!we_q) rdata_d = ld_data;
            default: ;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == RSP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

endmodule
